// File: rtl/imem_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: loader state encoding, bytes-per-word and length-field width.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Purpose: byte-stream and imem write-port bundle for the loader.
// Latency: n/a (wiring only).
// Backpressure: s_ready from the loader throttles the byte source.
// Ports: s_valid/s_ready/s_data byte stream; mem_we/mem_addr/mem_wd imem write port.
//        master = loader side, slave = byte source / imem side.
interface imem_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wd;

   modport master (
      input  s_valid, s_data,
      output s_ready, mem_we, mem_addr, mem_wd
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Purpose: packs little-endian bytes into 32-bit words.
// Latency: word_vld pulses the cycle after the 4th byte of a word is accepted.
// Backpressure: none; caller only presents byte_vld on accepted bytes.
// Ports: clk, reset (async high); clr restarts at lane 0; byte_vld/byte_dat
//        accepted byte; lane current byte lane; word_vld/word_dat assembled word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   output logic [LANE_W-1:0] lane,
   output logic              word_vld,
   output logic [31:0]       word_dat
);

   // Right shift register: after four bytes the first byte sits in [7:0].
   // A byte arriving during the write cycle shifts only at the end of that
   // cycle, so word_dat is stable while word_vld is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane     <= '0;
         word_vld <= 1'b0;
         word_dat <= '0;
      end else begin
         word_vld <= 1'b0;
         if (clr) begin
            lane <= '0;
         end else if (byte_vld) begin
            word_dat <= {byte_dat, word_dat[31:8]};
            lane     <= lane + 1'b1;
            if (lane == LANE_W'(BYTES_PER_WORD - 1))
               word_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Purpose: streams a length-prefixed program into imem while holding the CPU in reset.
// Latency: mem_we one cycle after a word's 4th byte; done/cpu_hold release two cycles after final handshake.
// Backpressure: s_ready high only in LEN_LO/LEN_HI/DATA/CSUM, including the write cycle (no bubble).
// Ports: clk, reset (async high), start pulse, bus (imem_loader_if.master: byte
//        stream in, imem write port out), cpu_hold, busy, done (sticky), err (sticky).
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1 << ADDR_W);

   state_t            state;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  wcnt;      // words fully received this session
   logic [ADDR_W-1:0] idx;       // address of the next imem write
   logic              fin_pend;  // session ended; publish status next cycle
   logic [LEN_W-1:0]  len_full;
   logic              accept;
   logic              data_acc;
   logic              start_go;
   logic [LANE_W-1:0] lane;
   logic              word_vld;
   logic [31:0]       word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign bus.s_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
   assign accept   = bus.s_valid & bus.s_ready;
   assign data_acc = accept && (state == DATA);
   assign start_go = start && !busy && ((state == IDLE) || (state == DONE));
   assign len_full = {bus.s_data, len[7:0]};

   assign bus.mem_we   = word_vld;
   assign bus.mem_addr = idx;
   assign bus.mem_wd   = DATA_W'(word_dat);

   imem_loader_byte_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .clr      (start_go),
      .byte_vld (data_acc),
      .byte_dat (bus.s_data),
      .lane     (lane),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         len      <= '0;
         wcnt     <= '0;
         idx      <= '0;
         fin_pend <= 1'b0;
         cpu_hold <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         if (word_vld)
            idx <= idx + 1'b1;

         // Status lags the final handshake by one extra cycle so the last
         // imem write completes before the CPU is released.
         if (fin_pend) begin
            fin_pend <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= err;
         end

         case (state)
            IDLE, DONE: begin
               if (start_go) begin
                  state    <= LEN_LO;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  len      <= '0;
                  wcnt     <= '0;
                  idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            LEN_LO: begin
               if (accept) begin
                  len[7:0] <= bus.s_data;
                  state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (accept) begin
                  len[15:8] <= bus.s_data;
                  if (len_full == '0) begin
                     state    <= DONE;
                     fin_pend <= 1'b1;
                  end else if (len_full > MAX_WORDS) begin
                     err      <= 1'b1;
                     state    <= DONE;
                     fin_pend <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum <= csum ^ bus.s_data;
`endif
                  if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
                     wcnt <= wcnt + 1'b1;
                     if (wcnt + 1'b1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CSUM;
`else
                        state    <= DONE;
                        fin_pend <= 1'b1;
`endif
                     end
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept) begin
                  if (bus.s_data != csum)
                     err <= 1'b1;
                  state    <= DONE;
                  fin_pend <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: self-checking bench for imem_loader with a write scoreboard.
// Latency: checks mem_we one cycle and done/cpu_hold two cycles after the final handshake.
// Backpressure: drives the byte stream with optional random valid gaps.
module tb_imem_loader;
   import imem_loader_pkg::*;

   typedef struct packed {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, busy, done, err;

   imem_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   imem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  wr_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every write pulse is matched against the expected queue.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (!reset && bus.mem_we === 1'b1) begin
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %h data %h", bus.mem_addr, bus.mem_wd);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_addr !== e.a || bus.mem_wd !== e.d) begin
               errors++;
               $display("FAIL write: got addr %h data %h want addr %h data %h",
                        bus.mem_addr, bus.mem_wd, e.a, e.d);
            end
         end
      end
   end

   function automatic logic [7:0] xor_data(input bq_t q);
      logic [7:0] x = 8'h00;
      for (int i = 2; i < q.size(); i++) x ^= q[i];
      return x;
   endfunction

   function automatic bq_t with_csum(input bq_t q);
      bq_t r = q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r.push_back(xor_data(q));
`endif
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int  n = 0;
      bit  sent = 1'b0;
      while (!sent) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 1) == 0) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
         end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = b;
            if (bus.s_ready === 1'b1) begin
               @(posedge clk);
               sent = 1'b1;
            end
         end
         n++;
         if (!sent && n > 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, got s_ready %b want 1", b, bus.s_ready);
            return;
         end
      end
   endtask

   task automatic send_all(input bq_t q, input bit gaps);
      for (int i = 0; i < q.size(); i++) send_byte(q[i], gaps);
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.s_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done_clr", 32'(done), 32'd0);
      chk("start_err_clr", 32'(err), 32'd0);
      chk("start_hold", 32'(cpu_hold), 32'd1);
   endtask

   // Called right after the final handshake edge.
   task automatic finish_check(input string tag, input bit exp_err);
      @(negedge clk);
      bus.s_valid = 1'b0;
      chk({tag, "_done_k1"}, 32'(done), 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err));
      chk({tag, "_rdy"}, 32'(bus.s_ready), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t q;
      int  w0;
      logic [7:0] b;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_rdy", 32'(bus.s_ready), 32'd0);
      chk("rst_we", 32'(bus.mem_we), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_hold", 32'(cpu_hold), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_err", 32'(err), 32'd0);
      chk("post_rst_rdy", 32'(bus.s_ready), 32'd0);

      // Two-word program, no gaps then with random valid gaps.
      for (int g = 0; g < 2; g++) begin
         do_start();
         q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h20, 8'h0C, 8'h00, 8'h03, 8'h20};
         exp_q.push_back('{a: 6'd0, d: 32'h2002_0005});
         exp_q.push_back('{a: 6'd1, d: 32'h2003_000C});
         w0 = wr_cnt;
         send_all(with_csum(q), g[0]);
         finish_check(g == 0 ? "two_words" : "two_words_gaps", 1'b0);
         chk("two_words_wr_cnt", 32'(wr_cnt - w0), 32'd2);
         chk("two_words_q_empty", 32'(exp_q.size()), 32'd0);
      end

      // Zero length: done with no writes, then a new start clears done.
      do_start();
      w0 = wr_cnt;
      q = '{8'h00, 8'h00};
      send_all(q, 1'b0);
      finish_check("len0", 1'b0);
      chk("len0_wr_cnt", 32'(wr_cnt - w0), 32'd0);
      do_start();

      // Length 65 overflows a 64-word imem.
      q = '{8'h41, 8'h00};
      send_all(q, 1'b0);
      finish_check("len65", 1'b1);
      repeat (3) @(negedge clk);
      chk("len65_rdy_after", 32'(bus.s_ready), 32'd0);
      chk("len65_wr_cnt", 32'(wr_cnt - w0), 32'd0);

      // Full depth (64 words) clears the previous error.
      do_start();
      q = '{8'h40, 8'h00};
      for (int i = 0; i < 256; i++) begin
         b = 8'(i * 7 + 3);
         q.push_back(b);
      end
      for (int w = 0; w < 64; w++)
         exp_q.push_back('{a: 6'(w), d: {q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]}});
      w0 = wr_cnt;
      send_all(with_csum(q), 1'b0);
      finish_check("len64", 1'b0);
      chk("len64_wr_cnt", 32'(wr_cnt - w0), 32'd64);
      chk("len64_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-session after one full word and one partial byte.
      do_start();
      q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h20, 8'h0C};
      exp_q.push_back('{a: 6'd0, d: 32'h2002_0005});
      w0 = wr_cnt;
      send_all(q, 1'b0);
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("abort_hold", 32'(cpu_hold), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rdy", 32'(bus.s_ready), 32'd0);
      reset = 1'b0;

      // New session after abort must start at lane 0 and address 0.
      do_start();
      q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      exp_q.push_back('{a: 6'd0, d: 32'hDDCC_BBAA});
      send_all(with_csum(q), 1'b1);
      finish_check("after_abort", 1'b0);
      chk("after_abort_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Wrong checksum byte (data XOR is 0x08, send 0x00).
      do_start();
      q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h20, 8'h0C, 8'h00, 8'h03, 8'h20, 8'h00};
      exp_q.push_back('{a: 6'd0, d: 32'h2002_0005});
      exp_q.push_back('{a: 6'd1, d: 32'h2003_000C});
      send_all(q, 1'b0);
      finish_check("bad_csum", 1'b1);
      chk("bad_csum_q_empty", 32'(exp_q.size()), 32'd0);
`endif

      repeat (5) @(negedge clk);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
